// File: rtl/bsg_downstream_in_assembler.sv
// Receive-side link assembler: gathers four 16-bit beats (ch1:ch0) into a
// 64-bit word, buffers words in a first-word-fall-through FIFO for the core
// (valid/yumi), and returns one credit pulse per TOKEN_RATIO dequeues.
module bsg_downstream_in_assembler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TOKEN_RATIO = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_valid_in,
    input  logic [7:0]                    io_data_in_ch0,
    input  logic [7:0]                    io_data_in_ch1,
    output logic                          io_token_out,
    output logic [63:0]                   core_data_out,
    output logic                          core_valid_out,
    input  logic                          core_yumi_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow_err,
    output logic                          framing_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TOKEN_RATIO) + 1;

    typedef enum logic [1:0] {BEAT0, BEAT1, BEAT2, BEAT3} beat_e;

    beat_e        beat_q;
    logic [47:0]  asm_q;          // beats 0..2; beat 3 is taken straight from the link
    logic         framing_err_q;

    logic [63:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tok_cnt_q, tok_cnt_d;
    logic          token_q, token_d;
    logic          overflow_q, overflow_d;

    logic [15:0]  beat;
    logic [63:0]  enq_word;
    logic         enq, deq, full, enq_ok, tok_hit;

    assign beat     = {io_data_in_ch1, io_data_in_ch0};
    assign enq      = io_valid_in && (beat_q == BEAT3);
    assign enq_word = {beat, asm_q};

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign deq      = core_yumi_in && (count_q != '0);
    // A full FIFO still takes the word if the head leaves in the same cycle.
    assign enq_ok   = enq && (!full || deq);
    assign tok_hit  = deq && (tok_cnt_q == TW'(TOKEN_RATIO - 1));

    // Beat-assembly FSM: stores beats 0..2, wraps on beat 3, aborts on a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q        <= BEAT0;
            asm_q         <= '0;
            framing_err_q <= 1'b0;
        end else if (io_valid_in) begin
            case (beat_q)
                BEAT0:   begin asm_q[15:0]  <= beat; beat_q <= BEAT1; end
                BEAT1:   begin asm_q[31:16] <= beat; beat_q <= BEAT2; end
                BEAT2:   begin asm_q[47:32] <= beat; beat_q <= BEAT3; end
                default: beat_q <= BEAT0;
            endcase
        end else if (beat_q != BEAT0) begin
            framing_err_q <= 1'b1;
            beat_q        <= BEAT0;
        end
    end

    // Next-state for FIFO pointers, occupancy, overflow flag and credit counter.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        tok_cnt_d  = tok_cnt_q;
        token_d    = tok_hit;
        if (deq)            rd_ptr_d   = rd_ptr_q + 1'b1;
        if (enq_ok)         wr_ptr_d   = wr_ptr_q + 1'b1;
        if (enq && !enq_ok) overflow_d = 1'b1;
        if (deq)            tok_cnt_d  = tok_hit ? '0 : tok_cnt_q + 1'b1;
        count_d = count_q + CW'(enq_ok) - CW'(deq);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tok_cnt_q  <= '0;
            token_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tok_cnt_q  <= tok_cnt_d;
            token_q    <= token_d;
            overflow_q <= overflow_d;
        end
    end

    // Word storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (enq_ok) mem_q[wr_ptr_q] <= enq_word;
    end

    assign core_data_out  = mem_q[rd_ptr_q];
    assign core_valid_out = (count_q != '0);
    assign fifo_count     = count_q;
    assign io_token_out   = token_q;
    assign overflow_err   = overflow_q;
    assign framing_err    = framing_err_q;

endmodule

// File: tb/tb_bsg_downstream_in_assembler.sv
// Directed plus randomized bench; expectations come from a queue-based model.
module tb_bsg_downstream_in_assembler;

    localparam int DEPTH = 8;
    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_valid_in = 1'b0;
    logic [7:0]  io_data_in_ch0 = '0;
    logic [7:0]  io_data_in_ch1 = '0;
    logic        core_yumi_in = 1'b0;
    logic        io_token_out;
    logic [63:0] core_data_out;
    logic        core_valid_out;
    logic [3:0]  fifo_count;
    logic        overflow_err;
    logic        framing_err;

    bsg_downstream_in_assembler #(.FIFO_DEPTH(DEPTH), .TOKEN_RATIO(RATIO)) dut (
        .clk(clk), .rst(rst),
        .io_valid_in(io_valid_in), .io_data_in_ch0(io_data_in_ch0), .io_data_in_ch1(io_data_in_ch1),
        .io_token_out(io_token_out), .core_data_out(core_data_out), .core_valid_out(core_valid_out),
        .core_yumi_in(core_yumi_in), .fifo_count(fifo_count),
        .overflow_err(overflow_err), .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic [63:0] m_q[$];
    logic [15:0] m_beats[$];
    logic        m_ovf = 1'b0, m_frm = 1'b0, m_tok = 1'b0;
    int          m_ndeq = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("core_valid_out", 64'(core_valid_out), 64'(m_q.size() != 0));
        chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
        chk("io_token_out", 64'(io_token_out), 64'(m_tok));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("framing_err", 64'(framing_err), 64'(m_frm));
        if (m_q.size() != 0) chk("core_data_out", core_data_out, m_q[0]);
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic step(input logic v, input logic [7:0] c0, input logic [7:0] c1,
                        input logic y, input logic r);
        logic        deq, enq, full;
        logic [63:0] w;
        rst = r; io_valid_in = v; io_data_in_ch0 = c0; io_data_in_ch1 = c1; core_yumi_in = y;
        w = '0;
        if (r) begin
            m_q.delete(); m_beats.delete();
            m_ovf = 1'b0; m_frm = 1'b0; m_tok = 1'b0; m_ndeq = 0;
        end else begin
            deq  = y && (m_q.size() != 0);
            full = (m_q.size() == DEPTH);
            enq  = 1'b0;
            if (v) begin
                m_beats.push_back({c1, c0});
                if (m_beats.size() == 4) begin
                    w = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
                    enq = 1'b1;
                    m_beats.delete();
                end
            end else if (m_beats.size() != 0) begin
                m_frm = 1'b1;
                m_beats.delete();
            end
            if (deq) begin
                void'(m_q.pop_front());
                m_ndeq++;
            end
            if (enq) begin
                if (full && !deq) m_ovf = 1'b1;
                else m_q.push_back(w);
            end
            m_tok = deq && (m_ndeq % RATIO == 0);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [63:0] w, input logic ylast);
        for (int k = 0; k < 4; k++)
            step(1'b1, w[16*k +: 8], w[16*k+8 +: 8], (k == 3) && ylast, 1'b0);
    endtask

    task automatic idle(input int n, input logic y);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 8'h00, y, 1'b0);
    endtask

    initial begin
        logic [63:0] rw;
        int ntok;

        // reset
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // 1: single word, beat mapping
        send_word(64'h7766554433221100, 1'b0);
        chk("t1_word", core_data_out, 64'h7766554433221100);
        chk("t1_count", 64'(fifo_count), 64'd1);
        idle(1, 1'b1);                      // drain it
        idle(1, 1'b1);                      // yumi while empty is ignored

        // 2: fill, then overflow
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) send_word({$urandom, $urandom}, 1'b0);
        chk("t2_full", 64'(fifo_count), 64'd8);
        send_word(64'hDEADBEEFCAFEF00D, 1'b0);
        chk("t2_ovf", 64'(overflow_err), 64'd1);
        chk("t2_count", 64'(fifo_count), 64'd8);

        // 3: full, last beat with yumi -> accepted
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) send_word({$urandom, $urandom}, 1'b0);
        send_word(64'h0123456789ABCDEF, 1'b1);
        chk("t3_no_ovf", 64'(overflow_err), 64'd0);
        chk("t3_count", 64'(fifo_count), 64'd8);

        // 4: dequeue all 8 -> two tokens
        ntok = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            ntok += int'(io_token_out);
        end
        idle(1, 1'b0);
        ntok += int'(io_token_out);
        chk("t4_tokens", 64'(ntok), 64'd2);
        chk("t4_last_word", core_valid_out == 1'b0 ? 64'd0 : 64'd1, 64'd0);

        // 5: framing error, then a good word
        rw = 64'hA5A5_5A5A_1234_8765;
        for (int k = 0; k < 3; k++) step(1'b1, rw[16*k +: 8], rw[16*k+8 +: 8], 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("t5_frm", 64'(framing_err), 64'd1);
        chk("t5_count", 64'(fifo_count), 64'd0);
        send_word(64'h1122334455667788, 1'b0);
        chk("t5_next_word", core_data_out, 64'h1122334455667788);

        // 6: reset mid-word with 3 buffered
        send_word({$urandom, $urandom}, 1'b0);
        send_word({$urandom, $urandom}, 1'b0);
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("t6_valid", 64'(core_valid_out), 64'd0);
        chk("t6_errs", 64'({overflow_err, framing_err}), 64'd0);
        send_word(64'hFEDCBA9876543210, 1'b0);
        chk("t6_word", core_data_out, 64'hFEDCBA9876543210);

        // randomized traffic: words, truncated words, idles, random yumi
        for (int n = 0; n < 300; n++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            end else begin
                len = (kind == 1) ? $urandom_range(1, 3) : 4;
                for (int k = 0; k < len; k++)
                    step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 99) < 45), 1'b0);
            end
            if (n == 150) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        end
        idle(12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
